// File: rtl/pipe_slice.sv
// Valid/ready pipeline slice: MODE 0 is a single-entry pass-through stage.
// MODE 1 is a two-entry skid buffer whose ready_o comes from a register.
module pipe_slice #(
  parameter int DATA_W = 64,
  parameter int MODE   = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              run_i,
  input  logic              flush_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              head_full_q, head_full_d;
  logic              skid_full_q, skid_full_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              in_xfer, out_xfer;

  assign valid_o  = !rst && head_full_q && run_i && !flush_i;
  assign data_o   = head_q;
  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = valid_o && ready_i;
  assign occ_o    = {1'b0, head_full_q} + {1'b0, skid_full_q};
  assign stall_cnt_o = stall_q;

  generate
    if (MODE == 0) begin : g_ready_pass
      assign ready_o = !rst && (!head_full_q || (run_i && ready_i));
    end else begin : g_ready_skid
      // Only the registered skid flag feeds ready_o; rst gates it off while held.
      assign ready_o = !rst && !skid_full_q;
    end
  endgenerate

  always_comb begin
    head_full_d = head_full_q;
    skid_full_d = skid_full_q;
    head_d      = head_q;
    skid_d      = skid_q;
    if (flush_i) begin
      head_full_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (MODE == 0) begin
      if (in_xfer) begin
        head_d      = data_i;
        head_full_d = 1'b1;
      end else if (out_xfer) begin
        head_full_d = 1'b0;
      end
    end else begin
      if (out_xfer && skid_full_q) begin
        head_d      = skid_q;
        skid_full_d = in_xfer;
        if (in_xfer) skid_d = data_i;
      end else if (out_xfer) begin
        head_full_d = in_xfer;
        if (in_xfer) head_d = data_i;
      end else if (in_xfer) begin
        if (!head_full_q) begin
          head_d      = data_i;
          head_full_d = 1'b1;
        end else begin
          skid_d      = data_i;
          skid_full_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (valid_o && !ready_i && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_full_q <= 1'b0;
      skid_full_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      head_full_q <= head_full_d;
      skid_full_q <= skid_full_d;
      stall_q     <= stall_d;
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_pipe_slice.sv
// Bench for pipe_slice: a MODE 0 instance and a MODE 1 instance with a 2-bit
// stall counter, directed scenarios plus per-instance in-order scoreboards.
module tb_pipe_slice;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] d0_data_i = '0, d0_data_o;
  logic          d0_valid_i = 1'b0, d0_ready_o, d0_valid_o;
  logic          d0_ready_i = 1'b1, d0_run_i = 1'b1, d0_flush_i = 1'b0;
  logic [1:0]    d0_occ_o;
  logic [7:0]    d0_stall_o;

  logic [DW-1:0] d1_data_i = '0, d1_data_o;
  logic          d1_valid_i = 1'b0, d1_ready_o, d1_valid_o;
  logic          d1_ready_i = 1'b1, d1_run_i = 1'b1, d1_flush_i = 1'b0;
  logic [1:0]    d1_occ_o;
  logic [1:0]    d1_stall_o;

  pipe_slice #(.DATA_W(DW), .MODE(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .data_i(d0_data_i), .valid_i(d0_valid_i),
    .ready_o(d0_ready_o), .data_o(d0_data_o), .valid_o(d0_valid_o),
    .ready_i(d0_ready_i), .run_i(d0_run_i), .flush_i(d0_flush_i),
    .occ_o(d0_occ_o), .stall_cnt_o(d0_stall_o));

  pipe_slice #(.DATA_W(DW), .MODE(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .data_i(d1_data_i), .valid_i(d1_valid_i),
    .ready_o(d1_ready_o), .data_o(d1_data_o), .valid_o(d1_valid_o),
    .ready_i(d1_ready_i), .run_i(d1_run_i), .flush_i(d1_flush_i),
    .occ_o(d1_occ_o), .stall_cnt_o(d1_stall_o));

  int n_chk  = 0;
  int n_pass = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: sampled mid-cycle, transfers resolve at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (d0_flush_i) q0.delete();
      else begin
        if (d0_valid_o && d0_ready_i) begin
          if (q0.size() == 0) check("d0_spurious_out", 1, 0);
          else check("d0_out_data", d0_data_o, q0.pop_front());
        end
        if (d0_valid_i && d0_ready_o) q0.push_back(d0_data_i);
      end
      if (d1_flush_i) q1.delete();
      else begin
        if (d1_valid_o && d1_ready_i) begin
          if (q1.size() == 0) check("d1_spurious_out", 1, 0);
          else check("d1_out_data", d1_data_o, q1.pop_front());
        end
        if (d1_valid_i && d1_ready_o) q1.push_back(d1_data_i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick; tick;
    check("rst_d0_occ", d0_occ_o, 0);
    check("rst_d0_valid", d0_valid_o, 0);
    check("rst_d0_ready", d0_ready_o, 0);
    check("rst_d1_occ", d1_occ_o, 0);
    check("rst_d1_valid", d1_valid_o, 0);
    check("rst_d1_ready", d1_ready_o, 0);
    check("rst_d1_stall", d1_stall_o, 0);
    rst = 1'b0;
    #1;
    check("rel_d0_ready", d0_ready_o, 1);
    check("rel_d1_ready", d1_ready_o, 1);

    // MODE 0 streaming, one-cycle latency, no bubbles
    d0_data_i = 16'd1; d0_valid_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      d0_data_i = DW'(k + 1);
      if (k == 6) d0_valid_i = 1'b0;
      #1;
      check("m0_stream_valid", d0_valid_o, 1);
      check("m0_stream_data", d0_data_o, k);
    end
    tick;
    check("m0_stream_drained", d0_occ_o, 0);

    // MODE 0 back-pressure: ready_o drops, payload held
    d0_ready_i = 1'b0; d0_valid_i = 1'b1; d0_data_i = 16'h55;
    tick;
    d0_valid_i = 1'b0;
    #1;
    check("m0_bp_ready", d0_ready_o, 0);
    check("m0_bp_occ", d0_occ_o, 1);
    tick;
    check("m0_bp_stall", d0_stall_o, 1);
    check("m0_bp_hold", d0_data_o, 16'h55);
    check("m0_bp_valid", d0_valid_o, 1);
    d0_ready_i = 1'b1;
    #1;
    check("m0_bp_ready_comb", d0_ready_o, 1);
    tick;
    check("m0_bp_drained", d0_occ_o, 0);

    // run_i = 0 holds the head beat invisibly
    d0_run_i = 1'b0; d0_valid_i = 1'b1; d0_data_i = 16'h21;
    tick;
    d0_valid_i = 1'b0;
    #1;
    check("run0_valid", d0_valid_o, 0);
    check("run0_occ", d0_occ_o, 1);
    check("run0_ready", d0_ready_o, 0);
    tick; tick;
    check("run0_stall", d0_stall_o, 1);
    check("run0_occ_hold", d0_occ_o, 1);
    d0_run_i = 1'b1;
    #1;
    check("run1_valid", d0_valid_o, 1);
    check("run1_data", d0_data_o, 16'h21);
    tick;
    check("run1_drained", d0_occ_o, 0);

    // MODE 0 flush with a real in-transfer in the same cycle
    d0_ready_i = 1'b0; d0_valid_i = 1'b1; d0_data_i = 16'h66;
    tick;
    d0_ready_i = 1'b1; d0_data_i = 16'h0C; d0_flush_i = 1'b1;
    #1;
    check("m0_flush_ready", d0_ready_o, 1);
    check("m0_flush_valid", d0_valid_o, 0);
    tick;
    d0_flush_i = 1'b0; d0_valid_i = 1'b0;
    #1;
    check("m0_flush_occ", d0_occ_o, 0);
    check("m0_flush_valid_after", d0_valid_o, 0);
    tick;
    check("m0_flush_no_0c", d0_valid_o, 0);

    // MODE 1 back-pressure: 0xA, 0xB into skid, three stall cycles
    d1_ready_i = 1'b0; d1_valid_i = 1'b1; d1_data_i = 16'hA;
    tick;
    d1_data_i = 16'hB;
    #1;
    check("m1_bp_ready1", d1_ready_o, 1);
    check("m1_bp_occ1", d1_occ_o, 1);
    tick;
    d1_valid_i = 1'b0;
    #1;
    check("m1_bp_occ2", d1_occ_o, 2);
    check("m1_bp_ready0", d1_ready_o, 0);
    check("m1_bp_stall1", d1_stall_o, 1);
    tick; tick;
    check("m1_bp_stall3", d1_stall_o, 3);
    check("m1_bp_head", d1_data_o, 16'hA);
    d1_ready_i = 1'b1;
    tick;
    check("m1_bp_second", d1_data_o, 16'hB);
    check("m1_bp_occ_after", d1_occ_o, 1);
    check("m1_bp_ready_after", d1_ready_o, 1);
    tick;
    check("m1_bp_drained", d1_occ_o, 0);

    // MODE 1 run_i = 0 fills skid, then flush with a beat offered
    d1_run_i = 1'b0; d1_valid_i = 1'b1; d1_data_i = 16'h31;
    tick;
    d1_data_i = 16'h32;
    #1;
    check("m1_run0_valid", d1_valid_o, 0);
    tick;
    d1_valid_i = 1'b0;
    #1;
    check("m1_run0_occ", d1_occ_o, 2);
    check("m1_run0_ready", d1_ready_o, 0);
    d1_flush_i = 1'b1; d1_valid_i = 1'b1; d1_data_i = 16'h0C;
    #1;
    check("m1_flush_valid", d1_valid_o, 0);
    tick;
    d1_flush_i = 1'b0; d1_valid_i = 1'b0; d1_run_i = 1'b1;
    #1;
    check("m1_flush_occ", d1_occ_o, 0);
    check("m1_flush_valid_after", d1_valid_o, 0);
    check("m1_flush_ready", d1_ready_o, 1);
    tick; tick;
    check("m1_flush_no_0c", d1_valid_o, 0);

    // Reset mid-operation with two beats held
    d1_ready_i = 1'b0; d1_valid_i = 1'b1; d1_data_i = 16'h41;
    tick;
    d1_data_i = 16'h42;
    tick;
    d1_valid_i = 1'b0;
    #1;
    check("m1_pre_rst_occ", d1_occ_o, 2);
    rst = 1'b1;
    tick;
    check("m1_rst_occ", d1_occ_o, 0);
    check("m1_rst_valid", d1_valid_o, 0);
    check("m1_rst_stall", d1_stall_o, 0);
    check("m1_rst_ready", d1_ready_o, 0);
    check("m0_rst_stall", d0_stall_o, 0);
    rst = 1'b0;
    #1;
    check("m1_rel_ready", d1_ready_o, 1);
    check("m0_rel_ready", d0_ready_o, 1);

    // 2-bit stall counter saturates at 3
    d1_valid_i = 1'b1; d1_data_i = 16'h51;
    tick;
    d1_valid_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick;
      check("m1_sat_stall", d1_stall_o, (k < 3) ? k : 3);
    end
    d1_ready_i = 1'b1;
    tick;
    check("m1_sat_drained", d1_occ_o, 0);
    tick;

    check("sb0_empty", q0.size(), 0);
    check("sb1_empty", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
